// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: state encoding and parity helper for the serial transmitter
package uart_tx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  function automatic logic parity_bit(input logic [7:0] d, input logic odd);
    return odd ? ~^d : ^d;
  endfunction
endpackage

// File: rtl/baudgen.vh
// baudgen.vh: clock cycles per bit for common baud rates at 12 MHz
`ifndef BAUDGEN_VH
`define BAUDGEN_VH
`define B115200 104
`define B57600 208
`define B38400 313
`define B19200 625
`define B9600 1250
`define B4800 2500
`define B2400 5000
`define B1200 10000
`define B600 20000
`define B300 40000
`endif

// File: rtl/baudgen_tx.sv
// baudgen_tx: modulo-BAUDRATE bit tick generator, parked at zero while disabled
`include "baudgen.vh"
module baudgen_tx #(
  parameter int BAUDRATE = `B115200
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_ena,
  output logic clk_out
);
  localparam int W = $clog2(BAUDRATE);
  localparam logic [W-1:0] TC = W'(BAUDRATE - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (!clk_ena || cnt == TC) ? '0 : cnt + 1'b1;
  assign clk_out = clk_ena && cnt == TC;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: LSB-first serial transmitter with optional parity and one or two stop bits
`include "baudgen.vh"
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int BAUDRATE   = `B115200,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);
  state_t state, state_nx;
  logic [7:0] sh;
  logic [2:0] bit_cnt;
  logic stop_cnt, par, tick, accept, tx_nx;
  assign ready = state == IDLE;
  assign accept = start && ready;
  baudgen_tx #(.BAUDRATE(BAUDRATE)) u_baud (
    .clk(clk),
    .rst(rst),
    .clk_ena(!ready),
    .clk_out(tick)
  );
  always_comb begin
    state_nx = state;
    tx_nx = tx;
    case (state)
      IDLE: if (accept) begin
        state_nx = START;
        tx_nx = 1'b0;
      end
      START: if (tick) begin
        state_nx = DATA;
        tx_nx = sh[0];
      end
      DATA: if (tick) begin
        state_nx = bit_cnt == 3'd7 ? (PARITY_EN ? PARITY : STOP) : DATA;
        tx_nx = bit_cnt == 3'd7 ? (PARITY_EN ? par : 1'b1) : sh[0];
      end
      PARITY: if (tick) begin
        state_nx = STOP;
        tx_nx = 1'b1;
      end
      STOP: if (tick && stop_cnt == LAST_STOP) state_nx = IDLE;
      default: begin
        state_nx = IDLE;
        tx_nx = 1'b1;
      end
    endcase
  end
  // sh always holds the next data bit in bit 0; it shifts as each bit goes out
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      sh <= '0;
      bit_cnt <= '0;
      stop_cnt <= 1'b0;
      par <= 1'b0;
    end else begin
      state <= state_nx;
      tx <= tx_nx;
      if (accept) begin
        sh <= data;
        par <= parity_bit(data, PARITY_ODD);
        bit_cnt <= '0;
        stop_cnt <= 1'b0;
      end else if (tick) begin
        sh <= (state == START || state == DATA) ? sh >> 1 : sh;
        bit_cnt <= state == DATA ? bit_cnt + 3'd1 : bit_cnt;
        stop_cnt <= state == STOP ? ~stop_cnt : stop_cnt;
      end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven and randomized checks of uart_tx against a frame-level model
module tb_uart_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] st, rd, txs;
  logic [7:0] dat [5];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  uart_tx #(.BAUDRATE(4)) u0 (.clk(clk), .rst(rst), .start(st[0]), .data(dat[0]), .ready(rd[0]), .tx(txs[0]));
  uart_tx #(.BAUDRATE(4), .PARITY_EN(1'b1)) u1 (.clk(clk), .rst(rst), .start(st[1]), .data(dat[1]), .ready(rd[1]), .tx(txs[1]));
  uart_tx #(.BAUDRATE(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u2 (.clk(clk), .rst(rst), .start(st[2]), .data(dat[2]), .ready(rd[2]), .tx(txs[2]));
  uart_tx #(.BAUDRATE(4), .STOP_BITS(2)) u3 (.clk(clk), .rst(rst), .start(st[3]), .data(dat[3]), .ready(rd[3]), .tx(txs[3]));
  uart_tx u4 (.clk(clk), .rst(rst), .start(st[4]), .data(dat[4]), .ready(rd[4]), .tx(txs[4]));
  function automatic int br(int i);
    return i == 4 ? 104 : 4;
  endfunction
  function automatic bit pe(int i);
    return i == 1 || i == 2;
  endfunction
  function automatic bit po(int i);
    return i == 2;
  endfunction
  function automatic int model_len(int i);
    return br(i) * (9 + int'(pe(i)) + (i == 3 ? 2 : 1));
  endfunction
  function automatic logic model_par(logic [7:0] d, bit odd);
    return 1'(($countones(d) + int'(odd)) % 2);
  endfunction
  function automatic logic exp_tx(int k, int b, bit p, logic [7:0] d, logic par, int len);
    int n = k / b;
    if (k >= len || n > 9 || (n == 9 && !p)) return 1'b1;
    if (n == 0) return 1'b0;
    if (n == 9) return par;
    return d[n-1];
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Called on a negedge with the instance idle; returns on the first ready cycle after the frame.
  task automatic send_frame(int i, logic [7:0] d, logic par, int len, bit noise);
    check($sformatf("u%0d ready before accept", i), 32'(rd[i]), 1);
    st[i] = 1'b1;
    dat[i] = d;
    @(negedge clk);
    st[i] = 1'b0;
    for (int k = 0; k <= len; k++) begin
      check($sformatf("u%0d %02h tx k=%0d", i, d, k), 32'(txs[i]), 32'(exp_tx(k, br(i), pe(i), d, par, len)));
      check($sformatf("u%0d %02h ready k=%0d", i, d, k), 32'(rd[i]), 32'(k >= len));
      if (noise) begin
        st[i] = k < len ? 1'($urandom) : 1'b0;
        dat[i] = 8'($urandom);
      end
      if (k < len) @(negedge clk);
    end
  endtask
  typedef struct {
    int inst;
    logic [7:0] d;
    logic par;
    int len;
  } vec_t;
  vec_t tbl [7];
  logic q [$];
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int ups, t, tend, zeros;
    logic prev;
    logic [7:0] by;
    tbl[0] = '{0, 8'h55, 1'b0, 40};
    tbl[1] = '{1, 8'h07, 1'b1, 44};
    tbl[2] = '{2, 8'h07, 1'b0, 44};
    tbl[3] = '{3, 8'hA5, 1'b0, 44};
    tbl[4] = '{4, 8'h3C, 1'b0, 1040};
    tbl[5] = '{1, 8'hFF, 1'b0, 44};
    tbl[6] = '{2, 8'h00, 1'b1, 44};
    st = '0;
    for (int i = 0; i < 5; i++) dat[i] = 8'h00;
    #1 rst = 1'b1;
    #1;
    check("reset tx", 32'(txs), 32'h1f);
    check("reset ready", 32'(rd), 32'h1f);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset tx", 32'(txs), 32'h1f);
    check("post-reset ready", 32'(rd), 32'h1f);
    for (int j = 0; j < 7; j++)
      send_frame(tbl[j].inst, tbl[j].d, tbl[j].par, tbl[j].len, j % 2 == 1);
    for (int r = 0; r < 40; r++) begin
      int i = int'($urandom_range(0, 3));
      logic [7:0] d = 8'($urandom);
      send_frame(i, d, model_par(d, po(i)), model_len(i), 1'b1);
    end
    // back-to-back: start held high across two frames, decoded by a sampling receiver
    @(negedge clk);
    q.delete();
    q.push_back(txs[0]);
    st[0] = 1'b1;
    dat[0] = 8'hA5;
    ups = 0;
    prev = 1'b1;
    for (int c = 1; c < 120; c++) begin
      @(negedge clk);
      q.push_back(txs[0]);
      if (rd[0] && !prev) ups++;
      prev = rd[0];
      dat[0] = 8'h3C;
      if (ups > 0 && !rd[0]) st[0] = 1'b0;
    end
    st[0] = 1'b0;
    t = 0;
    tend = 0;
    for (int f = 0; f < 2; f++) begin
      while (t < q.size() && q[t]) t++;
      if (f == 0) check("b2b first start offset", 32'(t), 1);
      else check("b2b idle gap", 32'(t - tend), 1);
      check($sformatf("b2b frame %0d present", f), 32'(t + 40 < q.size()), 1);
      if (t + 40 < q.size()) begin
        for (int j = 0; j < 8; j++) by[j] = q[t + 2 + 4 * (j + 1)];
        check($sformatf("b2b frame %0d stop", f), 32'(q[t + 38]), 1);
        check($sformatf("b2b frame %0d byte", f), 32'(by), f == 0 ? 32'hA5 : 32'h3C);
      end
      tend = t + 40;
      t = tend;
    end
    zeros = 0;
    for (int c = tend; c < q.size(); c++) zeros += int'(!q[c]);
    check("b2b no extra frame", 32'(zeros), 0);
    // reset in the middle of data bit 3
    @(negedge clk);
    st[0] = 1'b1;
    dat[0] = 8'h00;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (17) @(negedge clk);
    check("data bit 3 before reset", 32'(txs[0]), 0);
    check("busy before reset", 32'(rd[0]), 0);
    #2 rst = 1'b1;
    #1;
    check("async reset tx", 32'(txs[0]), 1);
    check("async reset ready", 32'(rd[0]), 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(0, 8'h81, 1'b0, 40, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
